multu_seq_unit: RTL and testbench
=================================

// Module: multu_seq_unit
// PURPOSE
//  Iterative 32x32 shift-add multiplier; the producer side of the HI/LO register.
//  Accepts a MULT/MULTU/MADD-type request from EX, computes the 64-bit product in
//  WIDTH+2 cycles and delivers it on MultuAns with a one-cycle hilo_we pulse and HL
//  (0 = overwrite HI/LO, 1 = accumulate into HI/LO). busy stalls the pipeline.
// PARAMETERS
//  WIDTH  32  operand width; product is 2*WIDTH bits.
// PORTS
//  clk        in   1        clock; all state updates on posedge clk
//  reset      in   1        synchronous, active-high reset
//  start      in   1        request; sampled only when busy==0
//  is_signed  in   1        1 = MULT (two's complement), 0 = MULTU
//  acc        in   1        1 = accumulate request (drives HL=1 on delivery)
//  op_a       in   WIDTH    multiplicand (rs)
//  op_b       in   WIDTH    multiplier (rt)
//  flush      in   1        abort in-flight op (branch/exception squash)
//  busy       out  1        op in flight; EX must stall MFHI/MFLO/new mult
//  done       out  1        one-cycle pulse: MultuAns valid
//  hilo_we    out  1        one-cycle HI/LO write strobe (== done)
//  HL         out  1        HI/LO mode for this write: 0 overwrite, 1 accumulate
//  MultuAns   out  2*WIDTH  product; held at last result between ops
// BEHAVIOUR
//  - Reset: state IDLE; busy=0, done=0, hilo_we=0, HL=0, MultuAns=0, counter=0.
//  - States: IDLE -> RUN -> FIX -> IDLE.
//    IDLE: start=1 at edge N -> latch |op_a|,|op_b| (magnitudes if is_signed, else
//      raw), neg = is_signed & (a[MSB]^b[MSB]), acc; clear partial product; -> RUN.
//    RUN: one bit per cycle: if mplier[0] add mcand to upper half; shift right 1
//      into 2*WIDTH+1-bit accumulator (carry kept). WIDTH steps at edges N+1..N+WIDTH;
//      at edge N+WIDTH -> FIX.
//    FIX: edge N+WIDTH+1: MultuAns <= neg ? -prod : prod; done=hilo_we=1; HL<=acc;
//      -> IDLE.
//  - Latency fixed: done high exactly in cycle after edge N+WIDTH+1 (33 cycles for
//    WIDTH=32), independent of operand values (zero operands take full latency).
//  - busy = (state != IDLE): high after edge N through the FIX cycle; low during
//    done cycle, so a new start may be sampled at edge N+WIDTH+2 (back-to-back).
//  - start while busy: ignored, no queuing. start with flush same edge: flush wins.
//  - flush in RUN/FIX: -> IDLE next edge, no done/hilo_we, MultuAns unchanged.
//  - reset mid-operation: immediate return to reset values; no write issued.
//  - Signed edge: |0x80000000| = 0x80000000 fits unsigned WIDTH bits; no overflow.
//  - done/hilo_we never high for more than one cycle; HL only meaningful with hilo_we.
// STRUCTURE
//  - Shared package: WIDTH default, state encoding (IDLE/RUN/FIX), counter width
//    $clog2(WIDTH).
//  - One sub-module natural: multu_step (combinational add-and-shift of one bit:
//    acc_in, mcand, mplier_bit -> acc_out). Control FSM and sign fix stay in top.
// TESTING
//  1 MULTU 3 x 5, start at edge N -> done at N+33, MultuAns=0x0000_0000_0000_000F,
//    HL=0, hilo_we one cycle, busy low in done cycle.
//  2 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE_00000001; MULT same operands
//    (-1 x -1) -> 0x0000_0000_0000_0001.
//  3 MULT 0x80000000 x 0x80000000 -> 0x4000_0000_0000_0000; MULT 0xFFFFFFFD x 5
//    (-3x5) -> 0xFFFF_FFFF_FFFF_FFF1.
//  4 acc=1, 7 x 6 -> MultuAns=0x2A with HL=1; start pulsed again at edge N+10 ->
//    ignored, single done at N+33.
//  5 flush at edge N+12 -> no done/hilo_we, busy low after N+12, MultuAns keeps prior
//    value; reset at N+5 -> all outputs 0, no write.
//  6 back-to-back: second start in done cycle -> second done exactly 33 cycles later.

Source files
------------

// File: rtl/multu_pkg.sv
// ---------------------------------------------------------------------------
// multu_pkg
//   Shared definitions for the iterative HI/LO multiplier:
//     MULTU_WIDTH   default operand width (product is twice this)
//     MULTU_CNT_W   step-counter width for the default operand width
//     multuState_t  control FSM encoding (IDLE -> RUN -> FIX -> IDLE)
// ---------------------------------------------------------------------------
package multu_pkg;

  localparam int MULTU_WIDTH = 32;
  localparam int MULTU_CNT_W = $clog2(MULTU_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } multuState_t;

endpackage

// File: rtl/multu_step.sv
// ---------------------------------------------------------------------------
// multu_step
//   Combinational add-and-shift for one multiplier bit.
//   Ports:
//     accIn   [2*WIDTH-1:0]  partial product {upper, remaining multiplier bits}
//     mcand   [WIDTH-1:0]    multiplicand magnitude
//     accOut  [2*WIDTH-1:0]  partial product after one step
//
//   The multiplier bit under test is accIn[0]; the multiplier sits in the
//   low half and is consumed from the bottom as the product shifts in from
//   the top. The addition carry is kept: it becomes the MSB after the right
//   shift, so the (2*WIDTH+1)-bit accumulator never needs its top bit stored
//   (that bit is always zero once the shift has happened).
// ---------------------------------------------------------------------------
module multu_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] accIn,
  input  logic [WIDTH-1:0]   mcand,
  output logic [2*WIDTH-1:0] accOut
);

  logic [WIDTH:0] upperSum;

  always_comb begin
    if (accIn[0]) begin
      upperSum = {1'b0, accIn[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
    end else begin
      upperSum = {1'b0, accIn[2*WIDTH-1:WIDTH]};
    end
    accOut = {upperSum, accIn[WIDTH-1:1]};
  end

endmodule

// File: rtl/multu_seq_unit.sv
// ---------------------------------------------------------------------------
// multu_seq_unit
//   Iterative shift-add multiplier feeding the HI/LO register. A request
//   is taken in IDLE, WIDTH add-shift steps run in RUN, and FIX applies the
//   sign and delivers the product with a one-cycle write strobe.
//   Ports:
//     clk, reset        clock; synchronous active-high reset
//     start             request, sampled only while idle
//     is_signed         1 = two's complement (MULT), 0 = unsigned (MULTU)
//     acc               1 = accumulate into HI/LO on delivery (HL=1)
//     op_a, op_b        multiplicand / multiplier
//     flush             abort in-flight op; also blocks a same-edge start
//     busy              op in flight (state != IDLE)
//     done, hilo_we     one-cycle pulse, MultuAns valid
//     HL                HI/LO mode for this write: 0 overwrite, 1 accumulate
//     MultuAns          product, held between operations
// ---------------------------------------------------------------------------
module multu_seq_unit
  import multu_pkg::*;
#(
  parameter int WIDTH = MULTU_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               is_signed,
  input  logic               acc,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  input  logic               flush,
  output logic               busy,
  output logic               done,
  output logic               hilo_we,
  output logic               HL,
  output logic [2*WIDTH-1:0] MultuAns
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  multuState_t        stateReg, stateNext;
  logic [CNT_W-1:0]   countReg;
  logic [2*WIDTH-1:0] prodReg;
  logic [2*WIDTH-1:0] prodStep;
  logic [WIDTH-1:0]   mcandReg;
  logic               negReg;
  logic               accModeReg;
  logic               doneReg;
  logic               hlReg;
  logic [2*WIDTH-1:0] ansReg;

  logic               loadOp;
  logic               finishOp;
  logic [WIDTH-1:0]   aMag;
  logic [WIDTH-1:0]   bMag;
  logic [2*WIDTH-1:0] fixedProd;

  // Magnitudes: the most negative value negates to itself, which read as
  // unsigned is exactly its magnitude, so no extra bit is needed.
  assign aMag = (is_signed && op_a[WIDTH-1]) ? -op_a : op_a;
  assign bMag = (is_signed && op_b[WIDTH-1]) ? -op_b : op_b;

  assign fixedProd = negReg ? -prodReg : prodReg;

  multu_step #(
    .WIDTH (WIDTH)
  ) stepInst (
    .accIn  (prodReg),
    .mcand  (mcandReg),
    .accOut (prodStep)
  );

  // Next-state and control decode.
  always_comb begin
    stateNext = stateReg;
    loadOp    = 1'b0;
    finishOp  = 1'b0;
    case (stateReg)
      IDLE: begin
        if (start && !flush) begin
          loadOp    = 1'b1;
          stateNext = RUN;
        end
      end
      RUN: begin
        if (flush) begin
          stateNext = IDLE;
        end else if (countReg == CNT_W'(WIDTH - 1)) begin
          stateNext = FIX;
        end
      end
      FIX: begin
        stateNext = IDLE;
        finishOp  = !flush;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg   <= IDLE;
      countReg   <= '0;
      prodReg    <= '0;
      mcandReg   <= '0;
      negReg     <= 1'b0;
      accModeReg <= 1'b0;
      doneReg    <= 1'b0;
      hlReg      <= 1'b0;
      ansReg     <= '0;
    end else begin
      stateReg <= stateNext;
      doneReg  <= finishOp;

      if (loadOp) begin
        countReg   <= '0;
        // Upper half cleared, multiplier loaded into the lower half.
        prodReg    <= {{WIDTH{1'b0}}, bMag};
        mcandReg   <= aMag;
        negReg     <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
        accModeReg <= acc;
      end else if (stateReg == RUN && !flush) begin
        prodReg  <= prodStep;
        countReg <= countReg + 1'b1;
      end

      if (finishOp) begin
        ansReg <= fixedProd;
        hlReg  <= accModeReg;
      end
    end
  end

  assign busy     = (stateReg != IDLE);
  assign done     = doneReg;
  assign hilo_we  = doneReg;
  assign HL       = hlReg;
  assign MultuAns = ansReg;

endmodule

// File: tb/tb_multu_seq_unit.sv
module tb_multu_seq_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic        acc;
  logic        flush;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic        hilo_we;
  logic        HL;
  logic [63:0] MultuAns;

  int checkCount = 0;
  int failCount  = 0;

  always #5 clk = ~clk;

  multu_seq_unit #(
    .WIDTH (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .acc       (acc),
    .op_a      (op_a),
    .op_b      (op_b),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .hilo_we   (hilo_we),
    .HL        (HL),
    .MultuAns  (MultuAns)
  );

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    if (obs !== exp) begin
      failCount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: drives a request across the next posedge (edge N)
  // and returns at the negedge right after it.
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic sgn, input logic accMode);
    op_a      = a;
    op_b      = b;
    is_signed = sgn;
    acc       = accMode;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  // Waits (bounded) for the write strobe, counting edges since edge N.
  // restartAt > 0 pulses start across edge N+restartAt with other operands.
  task automatic waitDone(input string tag, input logic [63:0] expProd,
                          input logic expHl, input int restartAt);
    int lat = -1;
    bit busyOk = 1'b1;
    if (!busy) busyOk = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (hilo_we) begin
        lat = i;
        break;
      end
      if (!busy) busyOk = 1'b0;
      if (restartAt > 0 && i == restartAt - 1) begin
        op_a  = 32'd100;
        op_b  = 32'd100;
        start = 1'b1;
      end else if (restartAt > 0 && i == restartAt) begin
        start = 1'b0;
      end
    end
    checkVal({tag, ".latency"}, 64'(lat), 64'd33);
    checkVal({tag, ".busy_held"}, 64'(busyOk), 64'd1);
    checkVal({tag, ".busy_in_done"}, 64'(busy), 64'd0);
    checkVal({tag, ".done"}, 64'(done), 64'd1);
    checkVal({tag, ".ans"}, MultuAns, expProd);
    checkVal({tag, ".HL"}, 64'(HL), 64'(expHl));
    $display("%s: a=0x%08h b=0x%08h signed=%0d acc=%0d -> ans=0x%016h HL=%0d latency=%0d",
             tag, op_a, op_b, is_signed, acc, MultuAns, HL, lat);
  endtask

  task automatic pulseEnd(input string tag);
    @(negedge clk);
    checkVal({tag, ".pulse_end"}, {62'd0, done, hilo_we}, 64'd0);
  endtask

  initial begin
    bit sawWe;
    reset     = 1'b1;
    start     = 1'b0;
    flush     = 1'b0;
    is_signed = 1'b0;
    acc       = 1'b0;
    op_a      = '0;
    op_b      = '0;
    repeat (3) @(negedge clk);
    checkVal("reset.busy", 64'(busy), 64'd0);
    checkVal("reset.done", 64'(done), 64'd0);
    checkVal("reset.hilo_we", 64'(hilo_we), 64'd0);
    checkVal("reset.HL", 64'(HL), 64'd0);
    checkVal("reset.ans", MultuAns, 64'd0);
    $display("reset: busy=%0d done=%0d ans=0x%0h", busy, done, MultuAns);
    reset = 1'b0;
    @(negedge clk);

    issue(32'd3, 32'd5, 1'b0, 1'b0);
    waitDone("multu_3x5", 64'h0000_0000_0000_000F, 1'b0, 0);
    pulseEnd("multu_3x5");

    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    waitDone("multu_max", 64'hFFFF_FFFE_0000_0001, 1'b0, 0);
    pulseEnd("multu_max");

    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    waitDone("mult_m1xm1", 64'h0000_0000_0000_0001, 1'b0, 0);
    pulseEnd("mult_m1xm1");

    issue(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
    waitDone("mult_min", 64'h4000_0000_0000_0000, 1'b0, 0);
    pulseEnd("mult_min");

    issue(32'hFFFF_FFFD, 32'd5, 1'b1, 1'b0);
    waitDone("mult_m3x5", 64'hFFFF_FFFF_FFFF_FFF1, 1'b0, 0);
    pulseEnd("mult_m3x5");

    // Accumulate request, with a start pulse at N+10 that must be ignored.
    issue(32'd7, 32'd6, 1'b0, 1'b1);
    waitDone("madd_7x6", 64'h0000_0000_0000_002A, 1'b1, 10);
    pulseEnd("madd_7x6");
    sawWe = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (hilo_we || busy) sawWe = 1'b1;
    end
    checkVal("madd_7x6.no_second_op", 64'(sawWe), 64'd0);

    // Back-to-back: second start driven during the done cycle.
    issue(32'd2, 32'd3, 1'b0, 1'b0);
    waitDone("b2b_first", 64'd6, 1'b0, 0);
    issue(32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0);
    waitDone("b2b_second", 64'h0000_0001_0000_0000, 1'b0, 0);
    pulseEnd("b2b_second");

    // Start and flush on the same edge: flush wins.
    flush = 1'b1;
    issue(32'd4, 32'd4, 1'b0, 1'b0);
    flush = 1'b0;
    checkVal("start_flush.busy", 64'(busy), 64'd0);
    $display("start_flush: busy=%0d", busy);

    // Flush at N+12.
    issue(32'd9, 32'd9, 1'b0, 1'b1);
    for (int i = 1; i <= 11; i++) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkVal("flush.busy", 64'(busy), 64'd0);
    checkVal("flush.hilo_we", 64'(hilo_we), 64'd0);
    sawWe = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (hilo_we || done) sawWe = 1'b1;
    end
    checkVal("flush.no_write", 64'(sawWe), 64'd0);
    checkVal("flush.ans_held", MultuAns, 64'h0000_0001_0000_0000);
    $display("flush: busy=%0d ans=0x%016h", busy, MultuAns);

    // Reset at N+5.
    issue(32'h0000_1234, 32'h0000_5678, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkVal("midreset.busy", 64'(busy), 64'd0);
    checkVal("midreset.done", 64'(done), 64'd0);
    checkVal("midreset.HL", 64'(HL), 64'd0);
    checkVal("midreset.ans", MultuAns, 64'd0);
    sawWe = 1'b0;
    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      if (hilo_we) sawWe = 1'b1;
    end
    checkVal("midreset.no_write", 64'(sawWe), 64'd0);
    $display("midreset: busy=%0d ans=0x%016h", busy, MultuAns);

    issue(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    waitDone("mult_maxpos_m1", 64'hFFFF_FFFF_8000_0001, 1'b0, 0);
    pulseEnd("mult_maxpos_m1");

    issue(32'd0, 32'hDEAD_BEEF, 1'b1, 1'b1);
    waitDone("madd_zero", 64'd0, 1'b1, 0);
    pulseEnd("madd_zero");

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
